// File: rtl/hc00_pkg.sv
// -----------------------------------------------------------------------------
// hc00_pkg
//   Shared definitions for the quad 2-input NAND tester.
//   - state_t        : tester FSM states
//   - NUM_GATES      : number of gates in the device under test
//   - NUM_VECS       : number of vectors in the test table
//   - VEC_A / VEC_B  : A and B values of each vector (bit i = vector i)
//   - VEC_EXP        : expected NAND output of each vector (bit i = vector i)
//   - replicate()    : spreads one vector bit across all gates
// -----------------------------------------------------------------------------
package hc00_pkg;

  localparam int NUM_GATES = 4;
  localparam int NUM_VECS  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Vector table, bit i holds vector i:
  //   idx0: A=0 B=0 -> Y=1
  //   idx1: A=1 B=0 -> Y=1
  //   idx2: A=1 B=1 -> Y=0
  //   idx3: A=0 B=1 -> Y=1
  // The A/B sequence changes one input per step.
  localparam logic [NUM_VECS-1:0] VEC_A   = 4'b0110;
  localparam logic [NUM_VECS-1:0] VEC_B   = 4'b1100;
  localparam logic [NUM_VECS-1:0] VEC_EXP = 4'b1011;

  // Every gate receives the same vector, so one table bit drives all gates.
  function automatic logic [NUM_GATES-1:0] replicate(input logic b);
    return {NUM_GATES{b}};
  endfunction

endpackage

// File: rtl/hc00_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Multi-stage flip-flop synchronizer for signals asynchronous to clk.
//   Every stage resets to all-ones so a freshly reset tester sees the
//   idle-state NAND output (A=B=0 -> Y=1) rather than a false low.
//
//   Parameters:
//     WIDTH  : number of independent bits synchronized
//     STAGES : flip-flop stages per bit (>= 1)
//   Ports:
//     clk : system clock
//     rst : synchronous, active-high reset
//     d   : asynchronous input bits
//     q   : synchronized output bits
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '1;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/hc00_tester.sv
// -----------------------------------------------------------------------------
// hc00_tester
//   Stimulus/check engine for a 74HC00-class quad 2-input NAND device.
//   On a start request it applies four A/B vectors to all four gates, holds
//   each for SETTLE_CYCLES clocks, samples the synchronized Y outputs for one
//   cycle and compares them against the expected NAND value. Results are
//   reported per gate and held until the next accepted start.
//
//   Parameters:
//     SETTLE_CYCLES : cycles each vector is held before sampling (3..255)
//     SYNC_STAGES   : synchronizer depth on dut_y (<= SETTLE_CYCLES-1)
//
//   Ports:
//     clk            : system clock, rising edge
//     rst            : synchronous, active-high reset
//     start          : run request
//     dut_a, dut_b   : A/B inputs of gates 0..3 (registered)
//     dut_y          : Y outputs of gates 0..3, asynchronous to clk
//     busy           : high from the cycle after an accepted start through
//                      the last SAMPLE cycle
//     done           : one-cycle pulse when results become valid
//     pass           : 1 = every gate matched on every vector
//     fail_mask      : bit g = gate g mismatched on at least one vector
//     first_fail_vec : index of the first vector with any mismatch
//     dbg_state      : current FSM state, for observation only
//
//   Handshake: start is a plain request with no ready. It is sampled on every
//   rising edge and accepted only while the FSM is in IDLE; a start seen in
//   any other state (including the DONE cycle) is dropped, never queued.
//
//   All outputs come straight from flops; dut_y only reaches them through the
//   synchronizer and the registered comparator.
// -----------------------------------------------------------------------------
module hc00_tester
  import hc00_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_GATES-1:0] dut_a,
  output logic [NUM_GATES-1:0] dut_b,
  input  logic [NUM_GATES-1:0] dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [1:0]           first_fail_vec,
  output state_t               dbg_state
);

  // Loading SETTLE_CYCLES-1 and leaving SETTLE on cnt==0 gives exactly
  // SETTLE_CYCLES cycles of SETTLE per vector.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [1:0]           idx, idx_nxt, idx_inc;
  logic [7:0]           cnt, cnt_nxt;
  logic                 seen_fail, seen_nxt;
  logic [NUM_GATES-1:0] a_nxt, b_nxt;
  logic [NUM_GATES-1:0] mask_nxt;
  logic                 pass_nxt;
  logic [1:0]           ffv_nxt;
  logic                 busy_nxt, done_nxt;
  logic [NUM_GATES-1:0] y_sync;
  logic [NUM_GATES-1:0] mismatch;

  sync_ff #(
    .WIDTH  (NUM_GATES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_y),
    .q   (y_sync)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      seen_fail      <= 1'b0;
      dut_a          <= '0;
      dut_b          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      seen_fail      <= seen_nxt;
      dut_a          <= a_nxt;
      dut_b          <= b_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      fail_mask      <= mask_nxt;
      first_fail_vec <= ffv_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  assign idx_inc  = idx + 2'd1;
  assign mismatch = y_sync ^ replicate(VEC_EXP[idx]);

  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    seen_nxt = seen_fail;
    a_nxt    = dut_a;
    b_nxt    = dut_b;
    mask_nxt = fail_mask;
    pass_nxt = pass;
    ffv_nxt  = first_fail_vec;

    case (state)
      IDLE: begin
        a_nxt = '0;
        b_nxt = '0;
        if (start) begin
          mask_nxt = '0;
          pass_nxt = 1'b0;
          ffv_nxt  = '0;
          seen_nxt = 1'b0;
          idx_nxt  = '0;
          a_nxt    = replicate(VEC_A[0]);
          b_nxt    = replicate(VEC_B[0]);
          cnt_nxt  = CNT_LOAD;
        end
      end

      SETTLE: begin
        if (cnt != '0) cnt_nxt = cnt - 8'd1;
      end

      SAMPLE: begin
        mask_nxt = fail_mask | mismatch;
        if ((mismatch != '0) && !seen_fail) begin
          ffv_nxt  = idx;
          seen_nxt = 1'b1;
        end
        if (idx == 2'd3) begin
          // Leaving for DONE: release the pins and publish the verdict,
          // which must include this final sample's mismatches.
          a_nxt    = '0;
          b_nxt    = '0;
          pass_nxt = (mask_nxt == '0);
        end else begin
          // The next vector goes out on the same edge that ends SAMPLE,
          // so all eight lines change together.
          idx_nxt = idx_inc;
          a_nxt   = replicate(VEC_A[idx_inc]);
          b_nxt   = replicate(VEC_B[idx_inc]);
          cnt_nxt = CNT_LOAD;
        end
      end

      DONE: begin
        a_nxt = '0;
        b_nxt = '0;
      end

      default: begin
        a_nxt = '0;
        b_nxt = '0;
      end
    endcase

    // busy/done are registered decodes of the state being entered, so they
    // line up with the state register without any combinational output path.
    busy_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
    done_nxt = (state_nxt == DONE);
  end

  assign dbg_state = state;

endmodule
